pixel_adc_readout: RTL and testbench
====================================

# pixel_adc_readout

Column-level single-slope ADC and readout stage placed directly downstream of the `pixelState` sequencer. During the `convert` phase it runs a ramp code counter and latches, per pixel, the code at which the pixel comparator trips. During the `read` phase it streams the latched codes out over a valid/ready interface, one pixel per beat, to the frame buffer.

## Interface
- `N_PIX`, 4: pixels handled. Must equal the width of `read`.
- `BITS`, 8: ADC code width. The ramp spans 0..2^BITS-1, matched to a 255-cycle convert phase.
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `convert` in 1: convert phase, level signal from `pixelState`.
- `read` in N_PIX: per-pixel read request from `pixelState`, level signal.
- `cmp` in N_PIX: comparator outputs from the analog front end. 1 means the ramp has crossed the pixel level. Already synchronised.
- `data_out` out BITS: code of the pixel being presented.
- `pix_idx` out $clog2(N_PIX): index of the presented pixel.
- `data_valid` out 1: `data_out` and `pix_idx` are valid.
- `data_ready` in 1: consumer accepts the beat.
- `overflow` out 1: set if any pixel failed to trip during the last conversion.
- `frame_done` out 1: one-cycle pulse when all N_PIX codes of a conversion have been accepted.

## Operation
- States:
  - IDLE: waiting.
  - CONV: ramp running.
  - READ: streaming codes out.
- Reset values: state IDLE, all counters and codes 0, latched/pending/served masks 0, and all outputs 0.
- Transitions:
  - IDLE → CONV on the first edge with `convert`=1.
  - CONV → READ on the first edge with `convert`=0.
  - READ → IDLE on the edge that completes the served mask.
  - Any state → CONV on a `convert` rising edge (restart).
- Entry into CONV, on the edge `convert` is first sampled high:
  - `cnt`←0.
  - Latched mask←0.
  - Served mask←0.
  - Pending mask←0.
  - `overflow`←0.
  - `data_valid`←0.
  - No capture happens on this edge.
- In CONV, on each edge with `convert`=1:
  - For each i with `cmp[i]`=1 and latched[i]=0: code[i]←`cnt` and latched[i]←1.
  - `cnt`←`cnt`+1, saturating at 2^BITS-1. It never wraps.
- On CONV exit:
  - Every pixel with latched=0 gets code←2^BITS-1.
  - `overflow`←1 if any pixel had latched=0.
- In READ:
  - pending |= `read` & ~served, each cycle.
  - While `data_valid`=0 and pending≠0: present the lowest pending index and set `data_valid`←1.
  - On an edge with `data_valid`&`data_ready`: served[idx]←1, pending[idx]←0, `data_valid`←0.
  - Each pixel is emitted at most once per conversion. Re-asserted `read` bits for served pixels are ignored.
- `read` asserted outside READ is ignored.
- `cmp` outside CONV is ignored.

## Timing
- A comparator first sampled high on the k-th CONV edge after entry (k≥1) yields code k-1.
- `data_valid` rises one cycle after the pending bit is set: the edge after `read` is sampled, or later if another beat is in flight.
- Valid/ready rules:
  - `data_out` and `pix_idx` stay stable while `data_valid`=1 and `data_ready`=0.
  - A beat completes on the edge where both are 1.
  - At most one beat per two cycles: valid drops for one cycle after each accept.
- Exception: a `convert` rising edge during READ aborts the stream. `data_valid` drops on that edge even if the beat was not accepted, and the unserved pixels are discarded.
- `frame_done` is high for exactly the one cycle after the final accept.
- Reset asserted mid-operation takes priority over everything: the block returns to reset values on that edge.

## Configuration
- `PIXEL_ADC_GRAY_EN` defined:
  - `cnt` is a Gray-code counter, matching the broadcast ramp code used by in-pixel latches.
  - Codes are stored as Gray.
  - A registered Gray→binary converter drives `data_out`, so `data_valid` rises one cycle later than stated above.
  - Saturation value is Gray(2^BITS-1).
- `PIXEL_ADC_GRAY_EN` undefined: binary counter, no converter stage, latencies exactly as stated above.
- `data_out` is always binary.

## Structure
- Shared package `pixel_pkg`:
  - state enum `adc_state_t` (IDLE, CONV, READ);
  - `ADC_BITS_DEF` = 8;
  - `N_PIX_DEF` = 4;
  - functions `bin2gray` and `gray2bin`.
- One sub-module, `ramp_counter`: the saturating BITS-wide counter with `clear`/`en` inputs. It is binary, or Gray under the macro.
- Capture array, pending arbiter and FSM are in the top module.

## Test plan
- Capture values:
  - Stimulus: N_PIX=4, BITS=8; `cmp[0]` high from start; `cmp[2]` first sampled high on CONV edge 101; 255 convert cycles; then `read`=4'b1111 with `data_ready`=1.
  - Response: beats in order idx 0,1,2,3; codes 0, 255, 100, 255; `overflow`=1; `frame_done` pulses once.
- Backpressure: hold `data_ready`=0 for 10 cycles with valid up → `data_out`/`pix_idx` stable; exactly one beat completes when ready rises.
- Out-of-order requests: `read`=4'b0100, then 4'b0001 two cycles later → idx 2 emitted first, then idx 0; repeated `read[2]` produces no second beat.
- Saturation: `convert` held 300 cycles, no `cmp` → all codes 255, no wrap, `overflow`=1.
- Abort: `convert` rises while idx 1 is valid and unaccepted → `data_valid` 0 on the next edge, codes cleared, new conversion captures correctly.
- Reset mid-conversion: reset at CONV edge 50 → all outputs 0; the next conversion starts from code 0. Repeat the full suite with `PIXEL_ADC_GRAY_EN` defined and check the +1 cycle valid latency.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared types, defaults and code-conversion helpers for the pixel ADC readout.
package pixel_pkg;

    localparam int ADC_BITS_DEF = 8;
    localparam int N_PIX_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        READ = 2'd2
    } adc_state_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down, done in log2(32) doubling steps.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int s = 1; s < 32; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/pixel_adc_readout_if.sv
// Readout stream from the ADC column to the frame buffer.
interface pixel_adc_readout_if #(
    parameter int N_PIX = 4,
    parameter int BITS  = 8
);
    localparam int IW = (N_PIX > 1) ? $clog2(N_PIX) : 1;

    // Handshake: a beat transfers on a rising clk edge where data_valid and
    // data_ready are both 1. While data_valid=1 and data_ready=0 the producer
    // holds data_out/pix_idx stable; the producer never waits on data_ready
    // to raise data_valid, and the consumer may toggle data_ready freely.
    logic [BITS-1:0] data_out;
    logic [IW-1:0]   pix_idx;
    logic            data_valid;
    logic            data_ready;

    modport master (output data_out, output pix_idx, output data_valid, input  data_ready);
    modport slave  (input  data_out, input  pix_idx, input  data_valid, output data_ready);

endinterface

// File: rtl/pixel_adc_readout_ramp_counter.sv
// Saturating ramp code counter; Gray-coded output when PIXEL_ADC_GRAY_EN is defined.
module ramp_counter
    import pixel_pkg::*;
#(
    parameter int BITS = ADC_BITS_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            en,
    output logic [BITS-1:0] cnt
);
    localparam logic [BITS-1:0] MAX = '1;

    logic [BITS-1:0] bin_q;
    logic [BITS-1:0] bin_n;

    always_comb begin
        bin_n = bin_q;
        if (clear) begin
            bin_n = '0;
        end else if (en && (bin_q != MAX)) begin
            bin_n = bin_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q <= '0;
        end else begin
            bin_q <= bin_n;
        end
    end

`ifdef PIXEL_ADC_GRAY_EN
    // Gray register follows the binary one so the broadcast code changes one bit per step.
    logic [BITS-1:0] gray_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            gray_q <= '0;
        end else begin
            gray_q <= BITS'(bin2gray(32'(bin_n)));
        end
    end

    assign cnt = gray_q;
`else
    assign cnt = bin_q;
`endif

endmodule

// File: rtl/pixel_adc_readout.sv
// Column single-slope ADC capture plus valid/ready readout of the latched codes.
// Optional Gray-coded ramp and output converter stage: PIXEL_ADC_GRAY_EN.
module pixel_adc_readout
    import pixel_pkg::*;
#(
    parameter int N_PIX = N_PIX_DEF,
    parameter int BITS  = ADC_BITS_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                convert,
    input  logic [N_PIX-1:0]    read,
    input  logic [N_PIX-1:0]    cmp,
    pixel_adc_readout_if.master rd,
    output logic                overflow,
    output logic                frame_done,
    output adc_state_t          dbg_state
);
    localparam int IW = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam logic [BITS-1:0] ALL1 = '1;
`ifdef PIXEL_ADC_GRAY_EN
    localparam logic [BITS-1:0] SAT = BITS'(bin2gray(32'(ALL1)));
`else
    localparam logic [BITS-1:0] SAT = ALL1;
`endif

    adc_state_t      state;
    adc_state_t      state_n;
    logic            convert_q;
    logic            go_conv;
    logic            accept;
    logic [N_PIX-1:0] latched;
    logic [N_PIX-1:0] pending;
    logic [N_PIX-1:0] served;
    logic [N_PIX-1:0] served_n;
    logic [N_PIX-1:0] pending_n;
    logic [N_PIX-1:0] acc_mask;
    logic [BITS-1:0] code [N_PIX];
    logic [BITS-1:0] cnt;
    logic [IW-1:0]   lo_idx;
    logic            lo_any;
`ifdef PIXEL_ADC_GRAY_EN
    logic            sel_vld;
    logic [IW-1:0]   sel_idx;
`endif

    assign dbg_state = state;

    ramp_counter #(.BITS(BITS)) u_ramp (
        .clk   (clk),
        .reset (reset),
        .clear (go_conv),
        .en    ((state == CONV) && convert && !go_conv),
        .cnt   (cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A convert rising edge restarts from any state; in IDLE a held level also starts.
    always_comb begin
        state_n  = state;
        go_conv  = convert && ((state == IDLE) || !convert_q);
        accept   = (state == READ) && rd.data_valid && rd.data_ready;
        acc_mask = '0;
        for (int i = 0; i < N_PIX; i++) begin
            acc_mask[i] = accept && (rd.pix_idx == IW'(i));
        end
        served_n  = served | acc_mask;
        pending_n = (pending | read) & ~served_n;
        lo_idx = '0;
        lo_any = 1'b0;
        for (int i = N_PIX - 1; i >= 0; i--) begin
            if (pending[i]) begin
                lo_idx = IW'(i);
                lo_any = 1'b1;
            end
        end
        if (go_conv) begin
            state_n = CONV;
        end else begin
            case (state)
                CONV:    if (!convert) state_n = READ;
                READ:    if (&served_n) state_n = IDLE;
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            convert_q     <= 1'b0;
            latched       <= '0;
            pending       <= '0;
            served        <= '0;
            overflow      <= 1'b0;
            frame_done    <= 1'b0;
            rd.data_valid <= 1'b0;
            rd.data_out   <= '0;
            rd.pix_idx    <= '0;
            for (int i = 0; i < N_PIX; i++) code[i] <= '0;
`ifdef PIXEL_ADC_GRAY_EN
            sel_vld <= 1'b0;
            sel_idx <= '0;
`endif
        end else begin
            convert_q  <= convert;
            frame_done <= 1'b0;
            if (go_conv) begin
                latched       <= '0;
                pending       <= '0;
                served        <= '0;
                overflow      <= 1'b0;
                rd.data_valid <= 1'b0;
                for (int i = 0; i < N_PIX; i++) code[i] <= '0;
`ifdef PIXEL_ADC_GRAY_EN
                sel_vld <= 1'b0;
`endif
            end else begin
                case (state)
                    CONV: begin
                        if (convert) begin
                            for (int i = 0; i < N_PIX; i++) begin
                                if (cmp[i] && !latched[i]) begin
                                    code[i]    <= cnt;
                                    latched[i] <= 1'b1;
                                end
                            end
                        end else begin
                            for (int i = 0; i < N_PIX; i++) begin
                                if (!latched[i]) code[i] <= SAT;
                            end
                            overflow <= ~&latched;
                        end
                    end
                    READ: begin
                        pending    <= pending_n;
                        served     <= served_n;
                        frame_done <= accept && (&served_n);
                        if (accept) rd.data_valid <= 1'b0;
`ifdef PIXEL_ADC_GRAY_EN
                        // Selection and Gray-to-binary conversion take one cycle each.
                        if (sel_vld) begin
                            rd.data_valid <= 1'b1;
                            rd.pix_idx    <= sel_idx;
                            rd.data_out   <= BITS'(gray2bin(32'(code[sel_idx])));
                            sel_vld       <= 1'b0;
                        end else if (!rd.data_valid && lo_any) begin
                            sel_vld <= 1'b1;
                            sel_idx <= lo_idx;
                        end
`else
                        if (!rd.data_valid && lo_any) begin
                            rd.data_valid <= 1'b1;
                            rd.pix_idx    <= lo_idx;
                            rd.data_out   <= code[lo_idx];
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_adc_readout.sv
// Directed bench for pixel_adc_readout: table of conversions plus hand-written corner sequences.
module tb_pixel_adc_readout;
    import pixel_pkg::*;

    localparam int N  = 4;
    localparam int B  = 8;
    localparam int IW = 2;
    localparam int W  = IW + B;
`ifdef PIXEL_ADC_GRAY_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         convert = 1'b0;
    logic [N-1:0] read = '0;
    logic [N-1:0] cmp = '0;
    logic         overflow;
    logic         frame_done;
    adc_state_t   dbg_state;

    pixel_adc_readout_if #(.N_PIX(N), .BITS(B)) rd ();

    pixel_adc_readout #(.N_PIX(N), .BITS(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .convert    (convert),
        .read       (read),
        .cmp        (cmp),
        .rd         (rd),
        .overflow   (overflow),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    int fd_cnt = 0;
    logic [W-1:0] exp_q[$];

    typedef struct packed {
        logic [15:0]           len;
        logic [N-1:0][15:0]    trip;
        logic [N-1:0][B-1:0]   code;
        logic                  ovf;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [N-1:0][15:0] mk_trip(input int t0, input int t1, input int t2, input int t3);
        logic [N-1:0][15:0] t;
        t[0] = 16'(t0); t[1] = 16'(t1); t[2] = 16'(t2); t[3] = 16'(t3);
        return t;
    endfunction

    function automatic vec_t mk(input int len, input int t0, input int t1, input int t2, input int t3,
                                input int c0, input int c1, input int c2, input int c3, input logic ovf);
        vec_t v;
        v.len = 16'(len);
        v.trip = mk_trip(t0, t1, t2, t3);
        v.code[0] = B'(c0); v.code[1] = B'(c1); v.code[2] = B'(c2); v.code[3] = B'(c3);
        v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input int code);
        exp_q.push_back({IW'(idx), B'(code)});
    endtask

    // Beats are judged on the values present just before the edge that accepts them.
    task automatic step();
        logic         acc;
        logic [W-1:0] beat;
        acc  = rd.data_valid && rd.data_ready;
        beat = {rd.pix_idx, rd.data_out};
        @(posedge clk);
        #1;
        if (frame_done) fd_cnt++;
        if (acc) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_beat: got idx %0d code %0d, expected no beat", beat[W-1:B], beat[B-1:0]);
            end else begin
                chk("beat", 32'(beat), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic conv_body(input int len, input logic [N-1:0][15:0] trip);
        for (int k = 1; k <= len; k++) begin
            for (int i = 0; i < N; i++) cmp[i] = (trip[i] != 0) && (k >= int'(trip[i]));
            step();
        end
        convert = 1'b0;
        cmp = '1;
        step();
        cmp = '0;
    endtask

    task automatic do_conv(input int len, input logic [N-1:0][15:0] trip);
        convert = 1'b1;
        cmp = '1;
        step();
        conv_body(len, trip);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!rd.data_valid && n < 20) begin
            step();
            n++;
        end
        chk(name, 32'(rd.data_valid), 32'd1);
    endtask

    task automatic end_frame(input string tag, input int exp_fd, input adc_state_t exp_st);
        chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_frame_done_pulses"}, 32'(fd_cnt), 32'(exp_fd));
        chk({tag, "_state"}, 32'(dbg_state), 32'(exp_st));
    endtask

    initial begin
        int n;
        vecs[0] = mk(255, 1, 0, 101, 0,     0, 255, 100, 255, 1'b1);
        vecs[1] = mk(300, 0, 0, 0, 0,       255, 255, 255, 255, 1'b1);
        vecs[2] = mk(255, 1, 2, 128, 255,   0, 1, 127, 254, 1'b0);
        vecs[3] = mk(10, 5, 10, 3, 1,       4, 9, 2, 0, 1'b0);
        vecs[4] = mk(300, 256, 260, 300, 0, 255, 255, 255, 255, 1'b1);
        rd.data_ready = 1'b0;

        repeat (3) step();
        chk("reset_valid", 32'(rd.data_valid), 32'd0);
        chk("reset_data", 32'(rd.data_out), 32'd0);
        chk("reset_idx", 32'(rd.pix_idx), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        chk("reset_state", 32'(dbg_state), 32'(IDLE));

        reset = 1'b0;
        read = '1;
        cmp = '1;
        repeat (5) step();
        chk("idle_read_ignored", 32'(rd.data_valid), 32'd0);
        chk("idle_state", 32'(dbg_state), 32'(IDLE));
        read = '0;
        cmp = '0;

        for (int v = 0; v < 5; v++) begin
            fd_cnt = 0;
            do_conv(int'(vecs[v].len), vecs[v].trip);
            chk($sformatf("vec%0d_overflow", v), 32'(overflow), 32'(vecs[v].ovf));
            chk($sformatf("vec%0d_state_read", v), 32'(dbg_state), 32'(READ));
            for (int i = 0; i < N; i++) push_exp(i, int'(vecs[v].code[i]));
            read = '1;
            rd.data_ready = 1'b1;
            n = 0;
            while (!rd.data_valid && n < 10) begin
                step();
                n++;
            end
            chk($sformatf("vec%0d_valid_latency", v), 32'(n), 32'(LAT + 1));
            repeat (24) step();
            read = '0;
            end_frame($sformatf("vec%0d", v), 1, IDLE);
        end

        // Backpressure: first beat must hold for 10 stalled cycles, then exactly one beat moves.
        fd_cnt = 0;
        rd.data_ready = 1'b0;
        do_conv(20, mk_trip(11, 2, 3, 4));
        read = '1;
        wait_valid("bp_first_valid");
        for (int c = 0; c < 10; c++) begin
            step();
            chk("bp_hold_valid", 32'(rd.data_valid), 32'd1);
            chk("bp_hold_idx", 32'(rd.pix_idx), 32'd0);
            chk("bp_hold_data", 32'(rd.data_out), 32'd10);
        end
        push_exp(0, 10); push_exp(1, 1); push_exp(2, 2); push_exp(3, 3);
        rd.data_ready = 1'b1;
        step();
        rd.data_ready = 1'b0;
        chk("bp_valid_drop", 32'(rd.data_valid), 32'd0);
        wait_valid("bp_second_valid");
        chk("bp_second_idx", 32'(rd.pix_idx), 32'd1);
        repeat (3) step();
        chk("bp_stall_queue", 32'(exp_q.size()), 32'd3);
        rd.data_ready = 1'b1;
        repeat (20) step();
        read = '0;
        end_frame("bp", 1, IDLE);

        // Out-of-order requests; a re-asserted read[2] must not produce a second beat.
        fd_cnt = 0;
        do_conv(20, mk_trip(1, 2, 3, 4));
        rd.data_ready = 1'b1;
        push_exp(2, 2); push_exp(0, 0);
        for (int c = 0; c < 30; c++) begin
            if (c == 0) read = 4'b0100;
            if (c == 2) read = 4'b0001;
            if (c == 10) read = 4'b0101;
            step();
        end
        end_frame("ooo_part", 0, READ);
        chk("ooo_idle_valid", 32'(rd.data_valid), 32'd0);
        push_exp(1, 1); push_exp(3, 3);
        read = 4'b1010;
        repeat (20) step();
        read = '0;
        end_frame("ooo", 1, IDLE);

        // Abort: convert rises while idx 1 is presented and not accepted.
        fd_cnt = 0;
        rd.data_ready = 1'b0;
        do_conv(20, mk_trip(1, 2, 3, 0));
        chk("abort_pre_overflow", 32'(overflow), 32'd1);
        read = 4'b0010;
        wait_valid("abort_valid");
        chk("abort_idx", 32'(rd.pix_idx), 32'd1);
        chk("abort_data", 32'(rd.data_out), 32'd1);
        convert = 1'b1;
        read = '0;
        step();
        chk("abort_valid_drop", 32'(rd.data_valid), 32'd0);
        chk("abort_state", 32'(dbg_state), 32'(CONV));
        chk("abort_overflow_clr", 32'(overflow), 32'd0);
        conv_body(10, mk_trip(0, 3, 0, 7));
        chk("abort_overflow", 32'(overflow), 32'd1);
        push_exp(0, 255); push_exp(1, 2); push_exp(2, 255); push_exp(3, 6);
        read = '1;
        rd.data_ready = 1'b1;
        repeat (24) step();
        read = '0;
        end_frame("abort", 1, IDLE);

        // Reset on CONV edge 50, then a fresh conversion must start from code 0.
        convert = 1'b1;
        cmp = '0;
        step();
        for (int k = 1; k < 50; k++) begin
            cmp = 4'b0001;
            step();
        end
        reset = 1'b1;
        step();
        chk("rst_valid", 32'(rd.data_valid), 32'd0);
        chk("rst_data", 32'(rd.data_out), 32'd0);
        chk("rst_idx", 32'(rd.pix_idx), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        convert = 1'b0;
        cmp = '0;
        step();
        reset = 1'b0;
        step();
        fd_cnt = 0;
        do_conv(5, mk_trip(1, 1, 2, 0));
        chk("rst_next_overflow", 32'(overflow), 32'd1);
        push_exp(0, 0); push_exp(1, 0); push_exp(2, 1); push_exp(3, 255);
        read = '1;
        repeat (24) step();
        read = '0;
        end_frame("rst_next", 1, IDLE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
